// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: FlappyBird game state sequencer with frame tick, flap edge detect and BCD score
module flappy_game_ctrl #(
  parameter int TICK_DIV  = 1_666_667,
  parameter int DEAD_HOLD = 60,
  parameter int MAX_SCORE = 999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_clr,
  input  logic        flap_req,
  input  logic        pass_pipe,
  input  logic        collide,
  output logic [1:0]  state,
  output logic        frame_tick,
  output logic        phys_en,
  output logic        flap_pulse,
  output logic [9:0]  score_bin,
  output logic [11:0] score_bcd
);
  typedef enum logic [1:0] {WAIT = 2'd0, FLY = 2'd1, DEAD = 2'd2} state_t;
  localparam int CW = $clog2(TICK_DIV);
  localparam int HW = $clog2(DEAD_HOLD + 1);
  state_t st, st_n;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hold, hold_n;
  logic flap_q, rise, tick_end, hold_done, score_clr, score_inc, flap_n;
  logic [11:0] bcd_inc;
  assign rise      = flap_req & ~flap_q;
  assign tick_end  = cnt == CW'(TICK_DIV - 1);
  assign hold_done = hold == HW'(DEAD_HOLD);
  assign state     = st;
  // tens below 9 means the +1 on {hundreds,tens} never carries into hundreds
  assign bcd_inc = score_bcd[3:0] != 4'd9 ? score_bcd + 12'd1
                 : score_bcd[7:4] != 4'd9 ? {score_bcd[11:4] + 8'd1, 4'd0}
                 : {score_bcd[11:8] + 4'd1, 8'd0};
  always_comb begin
    st_n      = st;
    hold_n    = hold;
    score_clr = 1'b0;
    score_inc = 1'b0;
    flap_n    = 1'b0;
    if (start_clr) begin
      st_n      = WAIT;
      score_clr = 1'b1;
      hold_n    = '0;
    end else begin
      case (st)
        WAIT: if (rise) begin
          st_n      = FLY;
          score_clr = 1'b1;
          flap_n    = 1'b1;
        end
        FLY: if (collide) begin
          st_n   = DEAD;
          hold_n = '0;
        end else begin
          score_inc = pass_pipe;
          flap_n    = rise;
        end
        DEAD: if (rise && hold_done) st_n = WAIT;
              else if (frame_tick && !hold_done) hold_n = hold + 1'b1;
        default: st_n = WAIT;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      st         <= WAIT;
      cnt        <= '0;
      hold       <= '0;
      flap_q     <= 1'b0;
      frame_tick <= 1'b0;
      phys_en    <= 1'b0;
      flap_pulse <= 1'b0;
      score_bin  <= '0;
      score_bcd  <= '0;
    end else begin
      st         <= st_n;
      cnt        <= tick_end ? '0 : cnt + 1'b1;
      hold       <= hold_n;
      flap_q     <= flap_req;
      frame_tick <= tick_end;
      phys_en    <= tick_end && st == FLY;
      flap_pulse <= flap_n;
      if (score_clr) begin
        score_bin <= '0;
        score_bcd <= '0;
      end else if (score_inc && score_bin != 10'(MAX_SCORE)) begin
        score_bin <= score_bin + 10'd1;
        score_bcd <= bcd_inc;
      end
    end
  end
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb_flappy_game_ctrl: table vectors plus scoreboarded per-cycle reference for flappy_game_ctrl
module tb_flappy_game_ctrl;
  logic clk = 1'b0, rst = 1'b0, start_clr = 1'b0, flap_req = 1'b0, pass_pipe = 1'b0, collide = 1'b0;
  logic [1:0] state;
  logic frame_tick, phys_en, flap_pulse;
  logic [9:0] score_bin;
  logic [11:0] score_bcd;
  int errors = 0, checks = 0;

  flappy_game_ctrl #(.TICK_DIV(4), .DEAD_HOLD(3), .MAX_SCORE(999)) dut (
    .clk(clk), .rst(rst), .start_clr(start_clr), .flap_req(flap_req), .pass_pipe(pass_pipe),
    .collide(collide), .state(state), .frame_tick(frame_tick), .phys_en(phys_en),
    .flap_pulse(flap_pulse), .score_bin(score_bin), .score_bcd(score_bcd));

  always #5 clk = ~clk;

  typedef struct {string name; logic [26:0] v;} exp_t;
  exp_t sb[$];
  typedef struct {logic sc, fr, pp, co; int rep; logic [1:0] st; int score; logic [11:0] bcd;} vec_t;

  int m_cnt = 0, m_hold = 0, m_score = 0, stepno = 0;
  logic [1:0] m_state = 2'd0;
  logic m_flapq = 1'b0, m_ft = 1'b0, m_pe = 1'b0, m_fp = 1'b0;

  function automatic logic [11:0] to_bcd(int s);
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // advance one clock: reference model predicts, scoreboard holds the prediction until the DUT is sampled
  task automatic step();
    logic rise, te, nfp;
    logic [1:0] ns;
    int nh, nsc;
    exp_t e;
    if (!rst) begin
      m_state = 0; m_cnt = 0; m_hold = 0; m_flapq = 0; m_score = 0; m_ft = 0; m_pe = 0; m_fp = 0;
    end else begin
      rise = flap_req && !m_flapq;
      te = m_cnt == 3;
      nfp = 0; ns = m_state; nh = m_hold; nsc = m_score;
      if (start_clr) begin ns = 0; nsc = 0; nh = 0; end
      else if (m_state == 2'd0) begin if (rise) begin ns = 1; nsc = 0; nfp = 1; end end
      else if (m_state == 2'd1) begin
        if (collide) begin ns = 2; nh = 0; end
        else begin
          if (pass_pipe && m_score < 999) nsc = m_score + 1;
          nfp = rise;
        end
      end else begin
        if (rise && m_hold == 3) ns = 0;
        else if (m_ft && m_hold < 3) nh = m_hold + 1;
      end
      m_pe = te && m_state == 2'd1;
      m_ft = te;
      m_cnt = (m_cnt + 1) % 4;
      m_flapq = flap_req;
      m_fp = nfp; m_state = ns; m_hold = nh; m_score = nsc;
    end
    e.name = $sformatf("cyc%0d", stepno);
    e.v = {m_state, m_ft, m_pe, m_fp, 10'(m_score), to_bcd(m_score)};
    sb.push_back(e);
    @(posedge clk);
    #1;
    stepno++;
    e = sb.pop_front();
    chk(e.name, 32'({state, frame_tick, phys_en, flap_pulse, score_bin, score_bcd}), 32'(e.v));
  endtask

  task automatic drive(logic sc, logic fr, logic pp, logic co);
    start_clr = sc; flap_req = fr; pass_pipe = pp; collide = co;
  endtask

  vec_t tbl[7];
  logic [11:0] tick_v, pe_v;
  int fp_n, ft_n, pe_n;

  initial begin
    tbl[0] = '{0, 0, 1, 0, 11,  2'd1, 11,  12'h011};
    tbl[1] = '{0, 0, 1, 0, 987, 2'd1, 998, 12'h998};
    tbl[2] = '{0, 0, 1, 0, 3,   2'd1, 999, 12'h999};
    tbl[3] = '{1, 0, 0, 0, 1,   2'd0, 0,   12'h000};
    tbl[4] = '{0, 1, 0, 0, 1,   2'd1, 0,   12'h000};
    tbl[5] = '{0, 0, 1, 0, 5,   2'd1, 5,   12'h005};
    tbl[6] = '{0, 0, 1, 1, 1,   2'd2, 5,   12'h005};

    step(); step();
    chk("rst_state", 32'(state), 0);
    chk("rst_bcd", 32'(score_bcd), 0);
    chk("rst_outs", 32'({frame_tick, phys_en, flap_pulse}), 0);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      tick_v[i] = frame_tick;
      pe_v[i] = phys_en;
    end
    chk("tick_every4", 32'(tick_v), 32'h888);
    chk("phys_wait", 32'(pe_v), 0);

    drive(0, 1, 0, 0);
    step();
    chk("launch_state", 32'(state), 1);
    fp_n = flap_pulse; ft_n = 0; pe_n = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      fp_n += flap_pulse; ft_n += frame_tick; pe_n += phys_en;
    end
    drive(0, 0, 0, 0);
    step();
    fp_n += flap_pulse;
    chk("held_one_flap", 32'(fp_n), 1);
    chk("phys_eq_tick", 32'(pe_n), 32'(ft_n));

    foreach (tbl[k]) begin
      for (int r = 0; r < tbl[k].rep; r++) begin
        drive(tbl[k].sc, tbl[k].fr, tbl[k].pp, tbl[k].co);
        step();
        drive(0, 0, 0, 0);
        step();
      end
      chk($sformatf("tbl%0d_state", k), 32'(state), 32'(tbl[k].st));
      chk($sformatf("tbl%0d_bin", k), 32'(score_bin), 32'(tbl[k].score));
      chk($sformatf("tbl%0d_bcd", k), 32'(score_bcd), 32'(tbl[k].bcd));
    end

    drive(0, 1, 0, 0); step();
    drive(0, 0, 0, 0); step();
    chk("dead_early_flap", 32'(state), 2);
    for (int i = 0; i < 40 && m_hold != 3; i++) step();
    chk("dead_hold_reached", 32'(m_hold), 3);
    chk("dead_still", 32'(state), 2);
    drive(0, 1, 0, 0); step();
    chk("restart_state", 32'(state), 0);
    chk("restart_score", 32'(score_bin), 5);
    drive(0, 0, 0, 0); step();
    drive(0, 1, 0, 0); step();
    chk("relaunch_state", 32'(state), 1);
    chk("relaunch_score", 32'(score_bcd), 0);
    drive(0, 0, 0, 0); step();

    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 1, 0); step();
      drive(0, 0, 0, 0); step();
    end
    chk("score7", 32'(score_bcd), 32'h007);
    drive(1, 0, 0, 0); step();
    chk("clr_state", 32'(state), 0);
    chk("clr_score", 32'(score_bin), 0);
    drive(1, 1, 0, 0); step();
    chk("clr_held_flap", 32'(state), 0);
    drive(0, 1, 0, 0); step();
    chk("clr_release_held", 32'(state), 0);
    drive(0, 0, 0, 0); step();
    drive(0, 1, 0, 0); step();
    drive(0, 0, 1, 0); step();
    drive(0, 0, 1, 0); step();
    chk("fly_again", 32'({state, score_bin}), 32'({2'd1, 10'd2}));
    rst = 1'b0;
    drive(0, 0, 0, 0); step();
    chk("midfly_rst", 32'({state, frame_tick, phys_en, flap_pulse, score_bin, score_bcd}), 0);
    rst = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
